// File: rtl/e1000_pkg.sv
// Shared e1000 core types: iDMA command field widths and the command record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package e1000_pkg;

  localparam int IDMA_ADDR_W  = 64;  // host address
  localparam int IDMA_LADDR_W = 16;  // local RAM address
  localparam int IDMA_LEN_W   = 16;  // transfer length in bytes

  typedef struct packed {
    logic [IDMA_ADDR_W-1:0]  src;
    logic [IDMA_LADDR_W-1:0] dst;
    logic [IDMA_LEN_W-1:0]   bytes;
  } idma_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: a push is visible on pop_dat the cycle after; the head is read combinationally.
// Backpressure: push is ignored when full and pop is ignored when empty; the caller watches full/empty.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, push_dat        write strobe and data
//   pop, pop_dat          read strobe and current head entry
//   count, full, empty    occupancy status
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign pop_dat = r_mem[r_rd_ptr];
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/idma_arbiter.sv
// Round-robin share of the single iDMA command channel; completions are routed back in issue order.
// Latency: the grant registers one cycle after req_valid; the response path is combinational.
// Backpressure: idma_ready stalls the held command; a full order FIFO blocks grants; rsp_ready of the head requester drives irpt_ready.
//
// Ports:
//   aclk, reset                      clock, synchronous active-high reset
//   req_* / req_valid / req_ready    per-requester command in (packed, requester i at slice i)
//   idma_* / idma_valid / idma_ready registered command out to the iDMA
//   irpt_* / irpt_valid / irpt_ready completion in from the iDMA
//   rsp_* / rsp_valid / rsp_ready    completion broadcast, one-hot valid
//   outstanding, err_orphan          in-flight count, pulse on a completion with nothing in flight
module idma_arbiter
  import e1000_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             aclk,
  input  logic                             reset,
  input  logic [IDMA_ADDR_W*NUM_REQ-1:0]   req_src_addr,
  input  logic [IDMA_LADDR_W*NUM_REQ-1:0]  req_dst_addr,
  input  logic [IDMA_LEN_W*NUM_REQ-1:0]    req_bytes,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [IDMA_ADDR_W-1:0]           idma_src_addr,
  output logic [IDMA_LADDR_W-1:0]          idma_dst_addr,
  output logic [IDMA_LEN_W-1:0]            idma_bytes,
  output logic                             idma_valid,
  input  logic                             idma_ready,
  input  logic [IDMA_ADDR_W-1:0]           irpt_src_addr,
  input  logic [IDMA_LADDR_W-1:0]          irpt_dst_addr,
  input  logic [IDMA_LEN_W-1:0]            irpt_bytes,
  input  logic                             irpt_valid,
  output logic                             irpt_ready,
  output logic [IDMA_ADDR_W-1:0]           rsp_src_addr,
  output logic [IDMA_LADDR_W-1:0]          rsp_dst_addr,
  output logic [IDMA_LEN_W-1:0]            rsp_bytes,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_orphan
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]         r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_grant;
  idma_cmd_t          r_cmd;
  logic               r_idma_valid;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_err_orphan;

  logic [IW-1:0]      w_gnt_idx;
  logic               w_gnt_found;
  logic               w_grant_take;
  logic               w_push;
  logic               w_pop;
  logic [IW-1:0]      w_head;
  logic [CW-1:0]      w_count;
  logic               w_full;
  logic               w_empty;

  // First valid requester at or after rr_ptr, wrapping upward.
  always_comb begin
    w_gnt_idx   = '0;
    w_gnt_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Full is judged on the count at grant time; since only one command is in
  // flight between grant and push, the later push always finds a free slot.
  assign w_grant_take = (r_state == S_IDLE) && w_gnt_found && !w_full;
  assign w_push       = (r_state == S_ISSUE) && r_idma_valid && idma_ready;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_cmd        <= '0;
      r_idma_valid <= 1'b0;
      r_req_ready  <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_req_ready  <= '0;
      r_err_orphan <= irpt_valid && w_empty;
      case (r_state)
        S_IDLE: begin
          if (w_grant_take) begin
            r_req_ready  <= NUM_REQ'(1) << w_gnt_idx;
            r_cmd.src    <= req_src_addr[IDMA_ADDR_W*w_gnt_idx +: IDMA_ADDR_W];
            r_cmd.dst    <= req_dst_addr[IDMA_LADDR_W*w_gnt_idx +: IDMA_LADDR_W];
            r_cmd.bytes  <= req_bytes[IDMA_LEN_W*w_gnt_idx +: IDMA_LEN_W];
            r_grant      <= w_gnt_idx;
            r_idma_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (idma_ready) begin
            r_idma_valid <= 1'b0;
            r_rr_ptr     <= (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + IW'(1);
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk      (aclk),
    .reset    (reset),
    .push     (w_push),
    .push_dat (r_grant),
    .pop      (w_pop),
    .pop_dat  (w_head),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  // With nothing in flight the completion is accepted and dropped so the iDMA
  // never wedges; err_orphan flags it one cycle later.
  assign rsp_valid  = (irpt_valid && !w_empty) ? (NUM_REQ'(1) << w_head) : '0;
  assign irpt_ready = w_empty ? 1'b1 : rsp_ready[w_head];
  assign w_pop      = irpt_valid && irpt_ready && !w_empty;

  assign rsp_src_addr  = irpt_src_addr;
  assign rsp_dst_addr  = irpt_dst_addr;
  assign rsp_bytes     = irpt_bytes;

  assign idma_src_addr = r_cmd.src;
  assign idma_dst_addr = r_cmd.dst;
  assign idma_bytes    = r_cmd.bytes;
  assign idma_valid    = r_idma_valid;
  assign req_ready     = r_req_ready;
  assign outstanding   = w_count;
  assign err_orphan    = r_err_orphan;

endmodule

// File: doc/idma_arbiter.md
# idma_arbiter

Shares the single iDMA command/response channel between NUM_REQ requesters (tx descriptor engine, tx data fetch, rx writeback). Round-robin arbitrates command submissions onto the registered idma_* port. The iDMA carries no transaction ID, so responses are routed back to the requester that issued them using an in-order grant FIFO. Sits between the engines and the iDMA block in the e1000 core.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- MAX_OUTSTANDING, 4: order-FIFO depth, a power of two, 2..16.
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_src_addr  in  64*NUM_REQ  per-requester host address, packed with requester i at [64i+63:64i]
- req_dst_addr  in  16*NUM_REQ  per-requester local RAM address
- req_bytes  in  16*NUM_REQ  per-requester transfer length
- req_valid  in  NUM_REQ  command valid
- req_ready  out  NUM_REQ  command accepted (one-hot or zero)
- idma_src_addr / idma_dst_addr / idma_bytes  out  64/16/16  registered command to iDMA
- idma_valid  out  1;  idma_ready  in  1
- irpt_src_addr / irpt_dst_addr / irpt_bytes  in  64/16/16  iDMA completion
- irpt_valid  in  1;  irpt_ready  out  1
- rsp_src_addr / rsp_dst_addr / rsp_bytes  out  64/16/16  completion broadcast to all requesters
- rsp_valid  out  NUM_REQ  one-hot completion valid
- rsp_ready  in  NUM_REQ
- outstanding  out  clog2(MAX_OUTSTANDING)+1  commands issued but not yet completed
- err_orphan  out  1  one-cycle pulse when a completion arrives with an empty FIFO

## Operation
- Issue FSM states: S_IDLE and S_ISSUE.
- S_IDLE:
  - If any req_valid is set and the FIFO is not full, grant the first requester at or after rr_ptr, searching upward with wrap.
  - Pulse req_ready[g] for one cycle.
  - Latch the granted requester's fields into idma_*, set idma_valid, and go to S_ISSUE.
- S_ISSUE:
  - Hold idma_* stable.
  - On idma_valid && idma_ready: clear idma_valid, push g into the FIFO, set rr_ptr = g+1 mod NUM_REQ, and return to S_IDLE.
- Full condition: grant is blocked only by the FIFO count at grant time, so a push is always guaranteed a slot. A pop in the same cycle does not unblock the grant until the next cycle.
- Response path is combinational:
  - head = FIFO head entry.
  - rsp_* = irpt_*.
  - rsp_valid = onehot(head) when irpt_valid and the FIFO is not empty.
  - irpt_ready = rsp_ready[head] when the FIFO is not empty.
  - Pop on irpt_valid && irpt_ready.
- Orphan completion (FIFO empty): irpt_ready = 1, the completion is dropped, and err_orphan pulses on the next cycle.
- outstanding = FIFO count. Simultaneous push and pop leave the count unchanged.
- Reset clears:
  - FIFO pointers and count
  - rr_ptr = 0
  - state = S_IDLE
  - idma_valid = 0, req_ready = 0, err_orphan = 0
- Reset mid-transfer drops in-flight bookkeeping. The iDMA must be reset together with this block.

## Timing
- Reset values:
  - idma_valid = 0, req_ready = 0, err_orphan = 0, outstanding = 0, rsp_valid = 0.
  - idma_* data = 0.
- Issue latency: req_valid high in cycle N with the FSM idle gives req_ready and idma_valid in cycle N+1.
- Minimum spacing between grants is 2 cycles (idma_ready tied high): grant, accept, grant.
- Requesters must hold their fields valid until req_ready. Fields are sampled on the grant edge only.
- Response path adds zero latency. irpt_valid must not depend on irpt_ready, and rsp_valid does not depend on rsp_ready.
- A push and a pop of the same entry can occur in the same cycle only if the FIFO was already non-empty. A completion never bypasses an empty FIFO.

## Structure
- Shared package e1000_pkg holds:
  - IDMA_ADDR_W = 64, IDMA_LADDR_W = 16, IDMA_LEN_W = 16.
  - The idma_cmd_t struct {src, dst, bytes}.
- Sub-module sync_fifo holds the order FIFO:
  - WIDTH = clog2(NUM_REQ), DEPTH = MAX_OUTSTANDING.
  - Outputs: count, full, empty.
  - First-word fall-through.
- Round-robin arbitration stays inline.

## Test plan
- Fairness: NUM_REQ=2, both req_valid held, idma_ready=1. Grants must alternate 0,1,0,1, and each grant is followed by a completion routed to the same index.
- Backpressure: idma_ready low for 5 cycles. idma_* must stay stable and no second req_ready may occur; the grant completes in the cycle idma_ready rises.
- Full FIFO: MAX_OUTSTANDING=4, issue 4 commands with no completions. A 5th req_valid gets no req_ready and outstanding=4. One completion (irpt_bytes=0x40) goes to the oldest requester, and the 5th is granted the following cycle.
- Ordering: issue to req 1, 0, 1. Completions carrying dst 0x100, 0x200, 0x300 must appear on rsp_valid 2'b10, 2'b01, 2'b10 in that order. Holding rsp_ready[1]=0 stalls irpt_ready.
- Orphan: irpt_valid with outstanding=0. Expect irpt_ready=1, err_orphan one pulse, and no rsp_valid.
- Reset mid-issue: assert reset while idma_valid=1. The next cycle shows idma_valid=0, outstanding=0, rr_ptr=0, and requester 0 wins first after release.
